// File: rtl/m_col_seq.sv
// Column phase sequencer: reset, write, settle, precharge and read pulses for NUM_COLS memristor columns.
// Latency: the first phase starts one cycle after an accepted start; each phase lasts its parameter in cycles.
// Handshake: start is taken only in IDLE (busy=0); abort returns to IDLE on the next edge; there is no other backpressure.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   start, abort             begin a sequence (IDLE only) / force return to IDLE
//   mode, n_reads            sequence selection and read count, latched on start
//   wr_mask, rd_mask         per-column enables, latched on start
//   rst_ctrl                 memristor reset drive
//   write_ctrl, read_ctrl    per-column write and read drives
//   gnd_ctrl                 column ground clamp
//   pre_charge_ctrl          precharge drive, active low
//   busy, done               sequence in progress / one-cycle completion pulse
//   rd_sample, read_idx      last-cycle-of-read strobe / current or last read index
module m_col_seq #(
   parameter int NUM_COLS = 2,
   parameter int CNT_W    = 8,
   parameter int RST_CYC  = 25,
   parameter int GAP_CYC  = 1,
   parameter int WR_CYC   = 10,
   parameter int PRE_CYC  = 1,
   parameter int RD_CYC   = 15,
   parameter int RGAP_CYC = 14,
   parameter int RD_W     = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [1:0]          mode,
   input  logic [RD_W-1:0]     n_reads,
   input  logic [NUM_COLS-1:0] wr_mask,
   input  logic [NUM_COLS-1:0] rd_mask,
   output logic                rst_ctrl,
   output logic [NUM_COLS-1:0] write_ctrl,
   output logic [NUM_COLS-1:0] read_ctrl,
   output logic                gnd_ctrl,
   output logic                pre_charge_ctrl,
   output logic                busy,
   output logic                done,
   output logic                rd_sample,
   output logic [RD_W-1:0]     read_idx
);

   typedef enum logic [3:0] {
      S_IDLE, S_RESET, S_GAP1, S_WRITE, S_GAP2, S_PRE, S_READ, S_RGAP, S_DONE
   } state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [RD_W-1:0]     idx_n;
   logic                accept;
   logic                expired;
   logic                more_reads;

   // Values captured at start so a sequence is immune to input changes mid-run.
   logic [1:0]          mode_q;
   logic [RD_W-1:0]     n_reads_q;
   logic [NUM_COLS-1:0] wr_mask_q;
   logic [NUM_COLS-1:0] rd_mask_q;

   // Counter preload on entering a state: DUR-1, so the state spans DUR cycles.
   // Untimed states (IDLE, DONE) preload 0.
   function automatic logic [CNT_W-1:0] load_val(input state_t s);
      case (s)
         S_RESET:         return CNT_W'(RST_CYC - 1);
         S_GAP1, S_GAP2:  return CNT_W'(GAP_CYC - 1);
         S_WRITE:         return CNT_W'(WR_CYC - 1);
         S_PRE:           return CNT_W'(PRE_CYC - 1);
         S_READ:          return CNT_W'(RD_CYC - 1);
         S_RGAP:          return CNT_W'(RGAP_CYC - 1);
         default:         return '0;
      endcase
   endfunction

   assign expired = (cnt == '0);

   // One extra bit so n_reads_q-1 never underflows; equivalent to read_idx < n_reads-1.
   assign more_reads = (({1'b0, read_idx} + (RD_W+1)'(1)) < {1'b0, n_reads_q});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         read_idx  <= '0;
         mode_q    <= '0;
         n_reads_q <= '0;
         wr_mask_q <= '0;
         rd_mask_q <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         read_idx <= idx_n;
         if (accept) begin
            mode_q    <= mode;
            n_reads_q <= n_reads;
            wr_mask_q <= wr_mask;
            rd_mask_q <= rd_mask;
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = read_idx;
      accept  = 1'b0;

      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               accept = 1'b1;
               idx_n  = '0;
               case (mode)
                  2'b01:   state_n = S_WRITE;
                  2'b10:   state_n = (n_reads == '0) ? S_DONE : S_PRE;
                  default: state_n = S_RESET;
               endcase
            end
         end
         S_RESET: if (expired) state_n = S_GAP1;
         // GAP1 is only reached in modes 00 and 11.
         S_GAP1:  if (expired) state_n = (mode_q == 2'b11) ? S_DONE : S_WRITE;
         S_WRITE: if (expired) state_n = S_GAP2;
         S_GAP2:  if (expired) state_n = (n_reads_q != '0) ? S_PRE : S_DONE;
         S_PRE:   if (expired) state_n = S_READ;
         S_READ:  if (expired) state_n = more_reads ? S_RGAP : S_DONE;
         S_RGAP: begin
            if (expired) begin
               state_n = S_PRE;
               idx_n   = read_idx + RD_W'(1);
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      // Abort overrides everything, including a simultaneous start in IDLE.
      if (abort) begin
         state_n = S_IDLE;
         idx_n   = read_idx;
      end

      if (state_n != state) begin
         cnt_n = load_val(state_n);
      end else if (!expired) begin
         cnt_n = cnt - CNT_W'(1);
      end
   end

   // Moore decode from the registered state and latched masks.
   always_comb begin
      rst_ctrl        = 1'b0;
      write_ctrl      = '0;
      read_ctrl       = '0;
      gnd_ctrl        = 1'b0;
      pre_charge_ctrl = 1'b1;
      busy            = 1'b1;
      done            = 1'b0;
      rd_sample       = 1'b0;

      case (state)
         S_IDLE: begin
            gnd_ctrl = 1'b1;
            busy     = 1'b0;
         end
         S_RESET: begin
            rst_ctrl = 1'b1;
            gnd_ctrl = 1'b1;
         end
         S_GAP1, S_GAP2: gnd_ctrl = 1'b1;
         S_WRITE: begin
            write_ctrl = wr_mask_q;
            gnd_ctrl   = 1'b1;
         end
         S_PRE:  pre_charge_ctrl = 1'b0;
         S_READ: begin
            read_ctrl = rd_mask_q;
            rd_sample = expired;
         end
         S_RGAP: ;
         S_DONE: done = 1'b1;
         default: begin
            gnd_ctrl = 1'b1;
            busy     = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_m_col_seq.sv
// Bench for m_col_seq: builds the expected per-cycle output stream from a list of phases and durations.
// Latency: expected stream starts one cycle after start; outputs are sampled on the falling clock edge.
// Handshake: start/abort/rst are driven on the falling edge; no backpressure to model.
module tb_m_col_seq;

   localparam int NC = 2;
   localparam int RW = 3;

   localparam int K_RST  = 0;
   localparam int K_GAP  = 1;
   localparam int K_WR   = 2;
   localparam int K_PRE  = 3;
   localparam int K_RD   = 4;
   localparam int K_RGAP = 5;
   localparam int K_DONE = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [RW-1:0] n_reads = '0;
   logic [NC-1:0] wr_mask = '0;
   logic [NC-1:0] rd_mask = '0;

   logic          rst_ctrl;
   logic [NC-1:0] write_ctrl;
   logic [NC-1:0] read_ctrl;
   logic          gnd_ctrl;
   logic          pre_charge_ctrl;
   logic          busy;
   logic          done;
   logic          rd_sample;
   logic [RW-1:0] read_idx;

   m_col_seq dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .abort           (abort),
      .mode            (mode),
      .n_reads         (n_reads),
      .wr_mask         (wr_mask),
      .rd_mask         (rd_mask),
      .rst_ctrl        (rst_ctrl),
      .write_ctrl      (write_ctrl),
      .read_ctrl       (read_ctrl),
      .gnd_ctrl        (gnd_ctrl),
      .pre_charge_ctrl (pre_charge_ctrl),
      .busy            (busy),
      .done            (done),
      .rd_sample       (rd_sample),
      .read_idx        (read_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          rst_c;
      logic [NC-1:0] wr;
      logic [NC-1:0] rd;
      logic          gnd;
      logic          pre;
      logic          busy;
      logic          done;
      logic          rds;
      logic [RW-1:0] idx;
   } obs_t;

   obs_t          q[$];
   int            vectors = 0;
   int            miscompares = 0;
   logic [RW-1:0] last_idx = '0;

   function automatic obs_t idle_vec(input logic [RW-1:0] idx);
      obs_t o;
      o     = '0;
      o.gnd = 1'b1;
      o.pre = 1'b1;
      o.idx = idx;
      return o;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.rst_c = rst_ctrl;
      o.wr    = write_ctrl;
      o.rd    = read_ctrl;
      o.gnd   = gnd_ctrl;
      o.pre   = pre_charge_ctrl;
      o.busy  = busy;
      o.done  = done;
      o.rds   = rd_sample;
      o.idx   = read_idx;
      return o;
   endfunction

   task automatic check(input string tag, input int cyc, input obs_t exp);
      obs_t got;
      int   drives;
      got = observe();
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, got, exp);
      end
      drives = int'(rst_ctrl) + int'(|write_ctrl) + int'(|read_ctrl) + int'(!pre_charge_ctrl);
      vectors++;
      assert (drives <= 1) else begin
         miscompares++;
         $error("FAIL %s_excl cycle=%0d observed=%0d active drives expected<=1", tag, cyc, drives);
      end
   endtask

   task automatic push_phase(input int kind, input int dur, input logic [RW-1:0] idx,
                             input logic [NC-1:0] wm, input logic [NC-1:0] rm);
      for (int c = 0; c < dur; c++) begin
         obs_t o;
         o      = '0;
         o.busy = 1'b1;
         o.pre  = 1'b1;
         o.idx  = idx;
         case (kind)
            K_RST:  begin o.rst_c = 1'b1; o.gnd = 1'b1; end
            K_GAP:  o.gnd = 1'b1;
            K_WR:   begin o.wr = wm; o.gnd = 1'b1; end
            K_PRE:  o.pre = 1'b0;
            K_RD:   begin o.rd = rm; o.rds = (c == dur - 1); end
            K_DONE: o.done = 1'b1;
            default: ;
         endcase
         q.push_back(o);
      end
   endtask

   // Expected stream for one sequence, one entry per cycle starting at cycle 1.
   task automatic build_seq(input logic [1:0] m, input int n,
                            input logic [NC-1:0] wm, input logic [NC-1:0] rm);
      q.delete();
      if (m == 2'b00 || m == 2'b11) begin
         push_phase(K_RST, 25, '0, wm, rm);
         push_phase(K_GAP, 1, '0, wm, rm);
      end
      if (m == 2'b00 || m == 2'b01) begin
         push_phase(K_WR, 10, '0, wm, rm);
         push_phase(K_GAP, 1, '0, wm, rm);
      end
      if (m != 2'b11) begin
         for (int i = 0; i < n; i++) begin
            push_phase(K_PRE, 1, RW'(i), wm, rm);
            push_phase(K_RD, 15, RW'(i), wm, rm);
            if (i < n - 1) push_phase(K_RGAP, 14, RW'(i), wm, rm);
         end
      end
      push_phase(K_DONE, 1, (m != 2'b11 && n > 0) ? RW'(n - 1) : RW'(0), wm, rm);
   endtask

   // Called on a falling edge with the DUT in IDLE. Optional start pulse, abort or reset at a given cycle.
   task automatic run_seq(input string tag, input logic [1:0] m, input int n,
                          input logic [NC-1:0] wm, input logic [NC-1:0] rm,
                          input int start_at, input int abort_at, input int rst_at);
      build_seq(m, n, wm, rm);
      start   = 1'b1;
      mode    = m;
      n_reads = RW'(n);
      wr_mask = wm;
      rd_mask = rm;
      @(negedge clk);
      start = 1'b0;
      // Scramble the live inputs: the sequence must run from the latched copies.
      mode    = 2'($urandom);
      n_reads = RW'($urandom);
      wr_mask = NC'($urandom);
      rd_mask = NC'($urandom);
      for (int k = 0; k < q.size(); k++) begin
         int c;
         c = k + 1;
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            check({tag, "_async_rst"}, c, idle_vec('0));
            #2;
            rst = 1'b0;
            @(negedge clk);
            check({tag, "_after_rst"}, c + 1, idle_vec('0));
            last_idx = '0;
            return;
         end
         check(tag, c, q[k]);
         start = (c == start_at);
         if (c == abort_at) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check({tag, "_abort"}, c + 1, idle_vec(q[k].idx));
            last_idx = q[k].idx;
            return;
         end
         @(negedge clk);
      end
      start = 1'b0;
      last_idx = q[q.size() - 1].idx;
      check({tag, "_idle"}, q.size() + 1, idle_vec(last_idx));
   endtask

   initial begin
      #1;
      check("reset_state", 0, idle_vec('0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", 0, idle_vec('0));

      // Full sequence with a start pulse while busy at cycle 40.
      run_seq("full_m00", 2'b00, 2, 2'b11, 2'b11, 40, 0, 0);
      // Same sequence aborted during the second read.
      run_seq("abort_m00", 2'b00, 2, 2'b11, 2'b11, 0, 75, 0);
      // A fresh start after the abort runs normally.
      run_seq("m01", 2'b01, 1, 2'b01, 2'b10, 0, 0, 0);
      run_seq("m10_zero_reads", 2'b10, 0, 2'b11, 2'b11, 0, 0, 0);
      run_seq("m11", 2'b11, 3, 2'b11, 2'b11, 0, 0, 0);
      run_seq("zero_masks", 2'b00, 1, 2'b00, 2'b00, 0, 0, 0);

      // start and abort together in IDLE: stays IDLE.
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_idle", 0, idle_vec(last_idx));
      @(negedge clk);
      check("start_abort_idle2", 0, idle_vec(last_idx));

      // Asynchronous reset during WRITE.
      run_seq("rst_mid_write", 2'b00, 2, 2'b11, 2'b11, 0, 0, 30);

      for (int r = 0; r < 14; r++) begin
         logic [1:0]    rm_mode;
         int            rn;
         logic [NC-1:0] rwm;
         logic [NC-1:0] rrm;
         rm_mode = 2'($urandom_range(0, 3));
         rn      = int'($urandom_range(0, 4));
         rwm     = NC'($urandom);
         rrm     = NC'($urandom);
         run_seq("random", rm_mode, rn, rwm, rrm, int'($urandom_range(2, 30)), 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
